// File: rtl/ysyx_25040118_mem_pkg.sv
// Shared types and constants for the memory responder.
package ysyx_25040118_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [31:0] MEM_BASE_DEFAULT = 32'h8000_0000;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    // Expand a 4-bit byte mask to a 32-bit bit mask
    function automatic logic [31:0] byte_expand(input logic [3:0] mask);
        return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    endfunction

endpackage

// File: rtl/ysyx_25040118_mem_resp_if.sv
// Request/response channel between the LSU-side initiator and the memory responder.
interface ysyx_25040118_mem_resp_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/ysyx_25040118_mem_bank.sv
// Word-organised RAM with a byte-enable write port and a registered read port.
module ysyx_25040118_mem_bank #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Storage is deliberately not reset; committed writes survive a reset
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ysyx_25040118_mem_resp.sv
// Single-outstanding memory responder: decode, lane shift, fault check and response FSM.
module ysyx_25040118_mem_resp
    import ysyx_25040118_mem_pkg::*;
#(
    parameter logic [31:0] MEM_BASE    = MEM_BASE_DEFAULT,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    ysyx_25040118_mem_resp_if.slave    bus
);

    localparam int unsigned AW   = $clog2(DEPTH_WORDS);
    localparam int unsigned CW   = 4;
    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);
    localparam logic [CW-1:0] LAT = CW'(LATENCY);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;
    logic [1:0]    lane_q, lane_d;
    logic [3:0]    mask_q, mask_d;
    logic          we_q, we_d;
    logic          fault_q, fault_d;

    logic [31:0]   off;
    logic [1:0]    lane;
    logic [AW-1:0] idx;
    logic [7:0]    emask;
    logic [31:0]   edata;
    logic          fault;
    logic          accept;
    logic [31:0]   rd_word;
    logic [31:0]   load_data;

    // Request decode: offset, word index, lane shift and fault detection
    assign off    = bus.req_addr - MEM_BASE;
    assign lane   = off[1:0];
    assign idx    = off[AW+1:2];
    assign emask  = 8'(bus.req_wmask) << lane;
    assign edata  = bus.req_wdata << {lane, 3'b000};
    assign fault  = (off >= SPAN) || (emask[7:4] != 4'h0);
    assign accept = (state_q == IDLE) && bus.req_valid && req_ready_q;

    ysyx_25040118_mem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_bank (
        .clk   (clk),
        .we    (accept && bus.req_we && !fault),
        .re    (accept && !bus.req_we && !fault),
        .addr  (idx),
        .be    (emask[3:0]),
        .wdata (edata),
        .rdata (rd_word)
    );

    // Load data is realigned to bit 0 and trimmed to the requested size
    assign load_data = (we_q || fault_q) ? 32'h0
                     : ((rd_word >> {lane_q, 3'b000}) & byte_expand(mask_q));

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        lane_d      = lane_q;
        mask_d      = mask_q;
        we_d        = we_q;
        fault_d     = fault_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    lane_d      = lane;
                    mask_d      = bus.req_wmask;
                    we_d        = bus.req_we;
                    fault_d     = fault;
                    cnt_d       = LAT;
                    req_ready_d = 1'b0;
                    state_d     = (LAT == '0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = load_data;
                    rsp_err_d   = fault_q;
                end else if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            lane_q      <= 2'b00;
            mask_q      <= 4'h0;
            we_q        <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            lane_q      <= lane_d;
            mask_q      <= mask_d;
            we_q        <= we_d;
            fault_q     <= fault_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ysyx_25040118_mem_resp.sv
// Bench for the memory responder: one instance with LATENCY=0 (index 0), one with LATENCY=2 (index 1).
module tb_ysyx_25040118_mem_resp;
    import ysyx_25040118_mem_pkg::*;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]       req_valid_v, req_we_v, rsp_ready_v;
    logic [1:0][31:0] req_addr_v, req_wdata_v;
    logic [1:0][3:0]  req_wmask_v;
    logic [1:0]       req_ready_v, rsp_valid_v, rsp_err_v;
    logic [1:0][31:0] rsp_rdata_v;

    int n_tests = 0;
    int n_fail  = 0;

    exp_t        sb0[$];
    exp_t        sb1[$];
    logic [31:0] mdl[int];

    ysyx_25040118_mem_resp_if if_l0();
    ysyx_25040118_mem_resp_if if_l2();

    assign if_l0.req_valid = req_valid_v[0];
    assign if_l0.req_we    = req_we_v[0];
    assign if_l0.req_addr  = req_addr_v[0];
    assign if_l0.req_wdata = req_wdata_v[0];
    assign if_l0.req_wmask = req_wmask_v[0];
    assign if_l0.rsp_ready = rsp_ready_v[0];
    assign req_ready_v[0]  = if_l0.req_ready;
    assign rsp_valid_v[0]  = if_l0.rsp_valid;
    assign rsp_rdata_v[0]  = if_l0.rsp_rdata;
    assign rsp_err_v[0]    = if_l0.rsp_err;

    assign if_l2.req_valid = req_valid_v[1];
    assign if_l2.req_we    = req_we_v[1];
    assign if_l2.req_addr  = req_addr_v[1];
    assign if_l2.req_wdata = req_wdata_v[1];
    assign if_l2.req_wmask = req_wmask_v[1];
    assign if_l2.rsp_ready = rsp_ready_v[1];
    assign req_ready_v[1]  = if_l2.req_ready;
    assign rsp_valid_v[1]  = if_l2.rsp_valid;
    assign rsp_rdata_v[1]  = if_l2.rsp_rdata;
    assign rsp_err_v[1]    = if_l2.rsp_err;

    ysyx_25040118_mem_resp #(
        .MEM_BASE (32'h8000_0000), .DEPTH_WORDS (1024), .LATENCY (0)
    ) u_dut_l0 (
        .clk (clk), .rst (rst), .bus (if_l0)
    );

    ysyx_25040118_mem_resp #(
        .MEM_BASE (32'h8000_0000), .DEPTH_WORDS (1024), .LATENCY (2)
    ) u_dut_l2 (
        .clk (clk), .rst (rst), .bus (if_l2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference behaviour of one access; updates the bench's copy of memory
    function automatic exp_t model(input int sel, input logic we, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [3:0] wmask);
        logic [31:0] off, word, ed, m;
        logic [1:0]  lane;
        logic [7:0]  em;
        int          key;
        exp_t        r;
        off  = addr - 32'h8000_0000;
        lane = off[1:0];
        em   = 8'(wmask) << lane;
        key  = sel * 1024 + 32'(off[11:2]);
        r    = '0;
        if (off >= 32'd4096 || em[7:4] != 4'h0) begin
            r.err = 1'b1;
            return r;
        end
        word = mdl.exists(key) ? mdl[key] : 32'h0;
        if (we) begin
            ed = wdata << {lane, 3'b000};
            for (int b = 0; b < 4; b++) if (em[b]) word[8*b +: 8] = ed[8*b +: 8];
            mdl[key] = word;
        end else begin
            m = '0;
            for (int b = 0; b < 4; b++) if (wmask[b]) m[8*b +: 8] = 8'hFF;
            r.rdata = (word >> {lane, 3'b000}) & m;
        end
        return r;
    endfunction

    task automatic push_exp(input int sel, input exp_t e);
        if (sel == 1) sb1.push_back(e);
        else          sb0.push_back(e);
    endtask

    task automatic pop_exp(input int sel, output exp_t e);
        int unsigned sz;
        sz = (sel == 1) ? sb1.size() : sb0.size();
        chk("sb_depth", 32'(sz), 32'd1);
        e = '0;
        if (sz != 0) e = (sel == 1) ? sb1.pop_front() : sb0.pop_front();
    endtask

    task automatic drive(input int sel, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask);
        req_we_v[sel]    = we;
        req_addr_v[sel]  = addr;
        req_wdata_v[sel] = wdata;
        req_wmask_v[sel] = mask;
        req_valid_v[sel] = 1'b1;
    endtask

    // One complete transaction with latency and handshake checks
    task automatic do_req(input int sel, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] mask, input string tag);
        exp_t e;
        int   cyc;
        int   lat;
        lat = (sel == 1) ? 2 : 0;
        @(negedge clk);
        drive(sel, we, addr, wdata, mask);
        cyc = 0;
        while (!req_ready_v[sel] && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_accept"}, 32'(req_ready_v[sel]), 32'd1);
        if (!req_ready_v[sel]) begin
            req_valid_v[sel] = 1'b0;
            return;
        end
        @(posedge clk);
        push_exp(sel, model(sel, we, addr, wdata, mask));
        @(negedge clk);
        req_valid_v[sel] = 1'b0;
        chk({tag, "_busy"}, 32'(req_ready_v[sel]), 32'd0);
        cyc = 0;
        while (!rsp_valid_v[sel] && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(lat + 1));
        pop_exp(sel, e);
        if (!rsp_valid_v[sel]) return;
        chk({tag, "_rdata"}, rsp_rdata_v[sel], e.rdata);
        chk({tag, "_err"}, 32'(rsp_err_v[sel]), 32'(e.err));
        rsp_ready_v[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready_v[sel] = 1'b0;
        chk({tag, "_vclr"}, 32'(rsp_valid_v[sel]), 32'd0);
        chk({tag, "_rdy"}, 32'(req_ready_v[sel]), 32'd1);
    endtask

    // Response held under backpressure while a stray request pulse arrives
    task automatic backpressure();
        exp_t e;
        int   cyc;
        @(negedge clk);
        drive(0, 1'b0, 32'h8000_0020, 32'h0, MASK_W);
        @(posedge clk);
        push_exp(0, model(0, 1'b0, 32'h8000_0020, 32'h0, MASK_W));
        @(negedge clk);
        req_valid_v[0] = 1'b0;
        cyc = 0;
        while (!rsp_valid_v[0] && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        pop_exp(0, e);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(rsp_valid_v[0]), 32'd1);
            chk("bp_rdata", rsp_rdata_v[0], e.rdata);
            chk("bp_ready", 32'(req_ready_v[0]), 32'd0);
            if (k == 2) drive(0, 1'b1, 32'h8000_0020, 32'h0, MASK_W);
            if (k == 3) req_valid_v[0] = 1'b0;
            @(negedge clk);
        end
        chk("bp_err", 32'(rsp_err_v[0]), 32'(e.err));
        req_valid_v[0] = 1'b0;
        rsp_ready_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready_v[0] = 1'b0;
        req_we_v[0]    = 1'b0;
    endtask

    // Four requests with req_valid and rsp_ready held high
    task automatic b2b();
        logic        t_we[4]    = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] t_addr[4]  = '{32'h8000_0030, 32'h8000_0030, 32'h8000_0032, 32'h8000_0030};
        logic [31:0] t_data[4]  = '{32'h1122_3344, 32'h0, 32'h0000_BEEF, 32'h0};
        logic [3:0]  t_mask[4]  = '{MASK_W, MASK_W, MASK_H, MASK_W};
        int          acc_cyc[4] = '{0, 0, 0, 0};
        int          nreq = 0;
        int          nrsp = 0;
        int          cyc  = 0;
        bit          acc, hs;
        exp_t        e;
        @(negedge clk);
        drive(0, t_we[0], t_addr[0], t_data[0], t_mask[0]);
        rsp_ready_v[0] = 1'b1;
        while (nrsp < 4 && cyc < 80) begin
            acc = req_valid_v[0] && req_ready_v[0];
            hs  = rsp_valid_v[0] && rsp_ready_v[0];
            if (hs) begin
                chk("b2b_ready_in_hs", 32'(req_ready_v[0]), 32'd0);
                pop_exp(0, e);
                chk("b2b_rdata", rsp_rdata_v[0], e.rdata);
                chk("b2b_err", 32'(rsp_err_v[0]), 32'(e.err));
                nrsp++;
            end
            if (acc) begin
                push_exp(0, model(0, t_we[nreq], t_addr[nreq], t_data[nreq], t_mask[nreq]));
                acc_cyc[nreq] = cyc;
                nreq++;
            end
            @(negedge clk);
            cyc++;
            if (acc) begin
                if (nreq < 4) drive(0, t_we[nreq], t_addr[nreq], t_data[nreq], t_mask[nreq]);
                else          req_valid_v[0] = 1'b0;
            end
        end
        req_valid_v[0] = 1'b0;
        rsp_ready_v[0] = 1'b0;
        chk("b2b_count", 32'(nrsp), 32'd4);
        for (int i = 0; i < 3; i++) chk("b2b_spacing", 32'(acc_cyc[i+1] - acc_cyc[i]), 32'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid_v = '0; req_we_v = '0; rsp_ready_v = '0;
        req_addr_v  = '0; req_wdata_v = '0; req_wmask_v = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_req_ready", 32'(req_ready_v[s]), 32'd1);
            chk("rst_rsp_valid", 32'(rsp_valid_v[s]), 32'd0);
            chk("rst_rsp_rdata", rsp_rdata_v[s], 32'h0);
            chk("rst_rsp_err", 32'(rsp_err_v[s]), 32'd0);
        end
        rst = 1'b1;

        // LATENCY=2 instance: word, byte lanes, faults, range boundaries
        do_req(1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, MASK_W, "w_st");
        do_req(1, 1'b0, 32'h8000_0010, 32'h0,         MASK_W, "w_ld");
        do_req(1, 1'b1, 32'h8000_0011, 32'h0000_00AA, MASK_B, "b_st");
        do_req(1, 1'b0, 32'h8000_0010, 32'h0,         MASK_W, "b_ldw");
        do_req(1, 1'b0, 32'h8000_0012, 32'h0,         MASK_H, "b_ldh");
        do_req(1, 1'b0, 32'h8000_0013, 32'h0,         MASK_B, "b_ldb");
        do_req(1, 1'b0, 32'h7FFF_FFFC, 32'h0,         MASK_W, "f_low");
        do_req(1, 1'b1, 32'h8000_0013, 32'h0000_5555, MASK_H, "f_cross");
        do_req(1, 1'b0, 32'h8000_0010, 32'h0,         MASK_W, "f_unch");
        do_req(1, 1'b1, 32'h8000_0FFC, 32'h0102_0304, MASK_W, "top_st");
        do_req(1, 1'b0, 32'h8000_0FFC, 32'h0,         MASK_W, "top_ld");
        do_req(1, 1'b0, 32'h8000_1000, 32'h0,         MASK_W, "f_high");
        do_req(1, 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, "m0_st");
        do_req(1, 1'b0, 32'h8000_0010, 32'h0,         4'b0000, "m0_ld");
        do_req(1, 1'b0, 32'h8000_0010, 32'h0,         MASK_W, "m0_chk");

        // Reset while the store is waiting for its response
        @(negedge clk);
        drive(1, 1'b1, 32'h8000_0040, 32'h1234_5678, MASK_W);
        @(posedge clk);
        void'(model(1, 1'b1, 32'h8000_0040, 32'h1234_5678, MASK_W));
        @(negedge clk);
        req_valid_v[1] = 1'b0;
        chk("rw_busy", 32'(req_ready_v[1]), 32'd0);
        #1 rst = 1'b0;
        #1;
        chk("rw_valid", 32'(rsp_valid_v[1]), 32'd0);
        chk("rw_ready", 32'(req_ready_v[1]), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        do_req(1, 1'b0, 32'h8000_0040, 32'h0, MASK_W, "rw_ld");

        // LATENCY=0 instance
        do_req(0, 1'b1, 32'h8000_0020, 32'hCAFE_F00D, MASK_W, "l0_st");
        backpressure();
        do_req(0, 1'b0, 32'h8000_0020, 32'h0, MASK_W, "bp_after");
        b2b();

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
